reservoir_sequencer: RTL and testbench

Control FSM that drives the time-multiplexed delay-feedback reservoir through a full input sequence. It reads pre-masked input values from an input sample memory and presents one value per virtual node to the reservoir. It pulses the reservoir enable, waits for the reservoir to settle, then writes each reservoir output into a state memory for the readout layer. The block sits between the AXI-configured register/BRAM layer and the reservoir datapath.

---
 rtl/dfr_pkg.sv | 8 +
 rtl/reservoir_sequencer.sv | 109 ++++++++++
 tb/tb_reservoir_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dfr_pkg.sv
// dfr_pkg: shared sequencer state type, default watchdog limit and memory-layout helper
package dfr_pkg;
  typedef enum logic [2:0] {IDLE, READ, FEED, WAIT, WRITE, DONE} seq_state_t;
  localparam int DEFAULT_WAIT_TIMEOUT = 15;
  function automatic int unsigned node_addr(input int unsigned s, input int unsigned n, input int unsigned vn);
    return s * vn + n;
  endfunction
endpackage

// File: rtl/reservoir_sequencer.sv
// reservoir_sequencer: steps the delay-feedback reservoir through every node of every input sample
module reservoir_sequencer
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int WAIT_TIMEOUT  = DEFAULT_WAIT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  res_en,
  output logic [DATA_WIDTH-1:0] res_din,
  input  logic [DATA_WIDTH-1:0] res_dout,
  input  logic                  res_valid,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int NW = VIRTUAL_NODES > 1 ? $clog2(VIRTUAL_NODES) : 1;
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  seq_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d, sample_q, sample_d, addr_q, addr_d;
  logic [NW-1:0] node_q, node_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic err_q, err_d, last_node, last;
  assign last_node = node_q == NW'(VIRTUAL_NODES - 1);
  assign last      = last_node && sample_q == num_q - ADDR_WIDTH'(1);
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    sample_d = sample_q;
    addr_d   = addr_q;
    node_d   = node_q;
    wd_d     = wd_q;
    din_d    = din_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start) begin
        num_d    = num_samples;
        sample_d = '0;
        node_d   = '0;
        addr_d   = '0;
        err_d    = 1'b0;
        state_d  = num_samples == '0 ? DONE : READ;
      end
      READ: state_d = FEED;
      FEED: begin
        din_d   = in_data;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: if (res_valid) state_d = WRITE;
      else if (wd_q == TW'(WAIT_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else wd_d = wd_q + TW'(1);
      WRITE: begin
        addr_d   = addr_q + ADDR_WIDTH'(1);
        node_d   = last_node ? '0 : node_q + NW'(1);
        sample_d = last_node ? sample_q + ADDR_WIDTH'(1) : sample_q;
        state_d  = last ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      sample_q <= '0;
      addr_q   <= '0;
      node_q   <= '0;
      wd_q     <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      sample_q <= sample_d;
      addr_q   <= addr_d;
      node_q   <= node_d;
      wd_q     <= wd_d;
      din_q    <= din_d;
      err_q    <= err_d;
    end
  end
  assign busy      = state_q inside {READ, FEED, WAIT, WRITE};
  assign done      = state_q == DONE;
  assign error     = err_q;
  assign in_rd_en  = state_q == READ;
  assign res_en    = state_q == FEED;
  assign out_wr_en = state_q == WRITE;
  assign in_addr   = addr_q;
  assign out_addr  = addr_q;
  // memory data arrives in FEED, so the reservoir sees it that same cycle and the register holds it afterwards
  assign res_din   = state_q == FEED ? in_data : din_q;
  assign out_data  = out_wr_en ? res_dout : '0;
endmodule

// File: tb/tb_reservoir_sequencer.sv
// tb_reservoir_sequencer: randomized self-checking bench with memory and reservoir models
module tb_reservoir_sequencer;
  localparam int VN = 10, DW = 32, AW = 16;
  logic clk = 0, rst = 0, start = 0;
  logic [AW-1:0] num_samples = '0;
  logic busy, done, error, in_rd_en, res_en, out_wr_en, res_valid;
  logic [AW-1:0] in_addr, out_addr;
  logic [DW-1:0] in_data, res_din, res_dout, out_data;
  logic [DW-1:0] mem [256];
  int lat = 1, res_cnt = 0;
  bit force_low = 0, pend = 0, prev_en = 0;
  int cyc = 0, vectors = 0, miscompares = 0, proto_err = 0, rd_cnt = 0, en_cnt = 0;
  logic [AW-1:0] wr_a [$];
  logic [DW-1:0] wr_d [$];

  reservoir_sequencer #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .busy(busy), .done(done),
    .error(error), .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data), .res_en(res_en),
    .res_din(res_din), .res_dout(res_dout), .res_valid(res_valid), .out_wr_en(out_wr_en),
    .out_addr(out_addr), .out_data(out_data));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // memory with one-cycle read latency and a reservoir that is busy for lat cycles after each step
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      in_data <= '0; res_dout <= '0; res_cnt <= 0;
    end else begin
      if (in_rd_en) in_data <= mem[in_addr[7:0]];
      if (res_en) begin res_dout <= f(res_din); res_cnt <= lat; end
      else if (res_cnt > 0) res_cnt <= res_cnt - 1;
    end
  end
  assign res_valid = !force_low && !res_en && res_cnt == 0;

  always @(negedge clk) begin
    if (out_wr_en) begin wr_a.push_back(out_addr); wr_d.push_back(out_data); end
    if (in_rd_en) rd_cnt++;
    if (res_en) en_cnt++;
    assert (!(res_en && prev_en)) else begin proto_err++; $display("FAIL res_en_width cycle %0d: res_en high 2 cycles, required 1", cyc); end
    assert (!(res_en && pend)) else begin proto_err++; $display("FAIL res_en_order cycle %0d: res_en again, required out_wr_en first", cyc); end
    assert (!(out_wr_en && !pend)) else begin proto_err++; $display("FAIL wr_order cycle %0d: out_wr_en without res_en, required res_en first", cyc); end
    assert (!(busy && done)) else begin proto_err++; $display("FAIL busy_done cycle %0d: busy=1 done=1, required not both", cyc); end
    prev_en = res_en;
    pend = !busy ? 1'b0 : res_en ? 1'b1 : out_wr_en ? 1'b0 : pend;
  end

  task automatic run(input int n, output int dt, output logic b0, output logic e0);
    @(negedge clk); num_samples = AW'(n); start = 1;
    @(negedge clk); start = 0;
    begin
      int t0 = cyc;
      b0 = busy; e0 = error; dt = -1;
      for (int i = 0; i < 4000 && dt < 0; i++) if (done) dt = cyc - t0; else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 0; repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, error, in_rd_en, res_en, out_wr_en} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b, required 000000", {busy, done, error, in_rd_en, res_en, out_wr_en});
    end
    vectors++;
    if ({in_addr, out_addr, res_din, out_data} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h %h %h %h, required all 0", in_addr, out_addr, res_din, out_data);
    end
    rst = 1;
  endtask

  task automatic test_single();
    int dt, wb = wr_a.size(), rb = rd_cnt, eb = en_cnt;
    logic b0, e0;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i + 1);
    run(1, dt, b0, e0);
    vectors++; if (dt !== 50) begin miscompares++; $display("FAIL single_latency: got %0d, required 50", dt); end
    vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b, required 1", b0); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL single_error: got %b, required 0", error); end
    vectors++; if (rd_cnt - rb !== VN || en_cnt - eb !== VN) begin
      miscompares++; $display("FAIL single_strobes: got rd=%0d en=%0d, required %0d", rd_cnt - rb, en_cnt - eb, VN);
    end
    vectors++; if (wr_a.size() - wb !== VN) begin miscompares++; $display("FAIL single_wcount: got %0d, required %0d", wr_a.size() - wb, VN); end
    for (int i = 0; i < VN && wb + i < wr_a.size(); i++) begin
      vectors++;
      if (wr_a[wb+i] !== AW'(i) || wr_d[wb+i] !== f(DW'(i + 1))) begin
        miscompares++; $display("FAIL single_write[%0d]: got %0d/%h, required %0d/%h", i, wr_a[wb+i], wr_d[wb+i], i, f(DW'(i + 1)));
      end
    end
  endtask

  task automatic test_zero();
    int dt, wb = wr_a.size(), rb = rd_cnt, eb = en_cnt;
    logic b0, e0;
    run(0, dt, b0, e0);
    vectors++; if (dt !== 0) begin miscompares++; $display("FAIL zero_latency: got %0d, required 0", dt); end
    vectors++; if (b0 !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b, required 0", b0); end
    vectors++; if (rd_cnt - rb !== 0 || en_cnt - eb !== 0 || wr_a.size() - wb !== 0) begin
      miscompares++; $display("FAIL zero_activity: got rd=%0d en=%0d wr=%0d, required 0", rd_cnt - rb, en_cnt - eb, wr_a.size() - wb);
    end
  endtask

  task automatic test_back_to_back();
    int dt, wb = wr_a.size();
    logic b0, e0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    fork
      run(3, dt, b0, e0);
      begin repeat (40) @(negedge clk); start = 1; num_samples = 7; @(negedge clk); start = 0; end
    join
    vectors++; if (dt !== 150) begin miscompares++; $display("FAIL restart_latency: got %0d, required 150", dt); end
    vectors++; if (wr_a.size() - wb !== 3 * VN) begin miscompares++; $display("FAIL restart_wcount: got %0d, required 30", wr_a.size() - wb); end
    for (int i = 0; i < 3 * VN && wb + i < wr_a.size(); i++) begin
      vectors++;
      if (wr_a[wb+i] !== AW'(i) || wr_d[wb+i] !== f(mem[i])) begin
        miscompares++; $display("FAIL restart_write[%0d]: got %0d/%h, required %0d/%h", i, wr_a[wb+i], wr_d[wb+i], i, f(mem[i]));
      end
    end
    wb = wr_a.size();
    run(1, dt, b0, e0);
    vectors++; if (dt !== 50 || wr_a.size() - wb !== VN) begin
      miscompares++; $display("FAIL rerun: got dt=%0d wr=%0d, required 50/%0d", dt, wr_a.size() - wb, VN);
    end
    vectors++; if (wr_a.size() > wb && wr_a[wb] !== '0) begin miscompares++; $display("FAIL rerun_addr: got %0d, required 0", wr_a[wb]); end
  endtask

  task automatic test_timeout();
    int dt, wb = wr_a.size(), eb = en_cnt;
    logic b0, e0;
    force_low = 1;
    run(2, dt, b0, e0);
    vectors++; if (dt !== 17) begin miscompares++; $display("FAIL timeout_latency: got %0d, required 17", dt); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL timeout_error: got %b, required 1", error); end
    vectors++; if (wr_a.size() - wb !== 0 || en_cnt - eb !== 1) begin
      miscompares++; $display("FAIL timeout_activity: got wr=%0d en=%0d, required 0/1", wr_a.size() - wb, en_cnt - eb);
    end
    repeat (3) @(negedge clk);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_hold: got %b, required 1", error); end
    force_low = 0;
    run(1, dt, b0, e0);
    vectors++; if (e0 !== 1'b0 || error !== 1'b0 || dt !== 50) begin
      miscompares++; $display("FAIL error_clear: got e=%b/%b dt=%0d, required 0/0 50", e0, error, dt);
    end
    lat = 14;
    run(1, dt, b0, e0);
    vectors++; if (error !== 1'b0 || dt !== VN * 18) begin
      miscompares++; $display("FAIL slow_limit: got e=%b dt=%0d, required 0 %0d", error, dt, VN * 18);
    end
    lat = 1;
  endtask

  task automatic test_midrun_reset();
    int dt, t0, wb;
    logic b0, e0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    wb = wr_a.size();
    @(negedge clk); num_samples = 3; start = 1;
    @(negedge clk); start = 0; t0 = cyc;
    while (cyc < t0 + 72) @(negedge clk);
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({busy, done, error, in_rd_en, res_en, out_wr_en} !== 6'b0 || {in_addr, out_addr, res_din, out_data} !== '0) begin
      miscompares++; $display("FAIL midreset_outputs: got ctrl=%b addr=%0d din=%h, required all 0", {busy, done, error, in_rd_en, res_en, out_wr_en}, in_addr, res_din);
    end
    vectors++; if (wr_a.size() - wb !== 14) begin miscompares++; $display("FAIL midreset_wcount: got %0d, required 14", wr_a.size() - wb); end
    rst = 1;
    wb = wr_a.size();
    run(2, dt, b0, e0);
    vectors++; if (dt !== 100 || wr_a.size() - wb !== 2 * VN) begin
      miscompares++; $display("FAIL after_reset: got dt=%0d wr=%0d, required 100/20", dt, wr_a.size() - wb);
    end
    for (int i = 0; i < 2 * VN && wb + i < wr_a.size(); i++) begin
      vectors++;
      if (wr_a[wb+i] !== AW'(i) || wr_d[wb+i] !== f(mem[i])) begin
        miscompares++; $display("FAIL after_reset_write[%0d]: got %0d/%h, required %0d/%h", i, wr_a[wb+i], wr_d[wb+i], i, f(mem[i]));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int dt, n, wb = wr_a.size();
      logic b0, e0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      lat = $urandom_range(0, 6);
      n = $urandom_range(1, 3);
      run(n, dt, b0, e0);
      vectors++; if (dt !== n * VN * (lat + 4) || error !== 1'b0) begin
        miscompares++; $display("FAIL random_latency[%0d]: got dt=%0d e=%b, required %0d 0", r, dt, error, n * VN * (lat + 4));
      end
      vectors++; if (wr_a.size() - wb !== n * VN) begin miscompares++; $display("FAIL random_wcount[%0d]: got %0d, required %0d", r, wr_a.size() - wb, n * VN); end
      for (int i = 0; i < n * VN && wb + i < wr_a.size(); i++) begin
        vectors++;
        if (wr_a[wb+i] !== AW'(i) || wr_d[wb+i] !== f(mem[i])) begin
          miscompares++; $display("FAIL random_write[%0d][%0d]: got %0d/%h, required %0d/%h", r, i, wr_a[wb+i], wr_d[wb+i], i, f(mem[i]));
        end
      end
    end
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_timeout();
    test_midrun_reset();
    test_random();
    repeat (2) @(negedge clk);
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL protocol: got %0d violations, required 0", proto_err); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
